// File: rtl/mxv_result_assembler_pkg.sv
// Shared definitions for the MxV result assembler: state encoding and the
// padding arithmetic that must match the matrix-by-vector stage exactly.
package mxv_result_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Padding rows needed to round the equation count up past the next granule.
  // An exact multiple still gets a full granule of padding, as upstream does.
  function automatic int calc_additional(input int eqn, input int ni);
    return ni - (eqn % ni);
  endfunction

  function automatic int calc_total(input int eqn, input int ni);
    return eqn + calc_additional(eqn, ni);
  endfunction

  function automatic int calc_beats(input int eqn, input int ni, input int units);
    return calc_total(eqn, ni) / units;
  endfunction

endpackage

// File: rtl/mxv_result_assembler_beat_writer.sv
// Combinational beat-to-slot mapper: for every real row slot it decides whether
// the current beat carries that row and which beat word feeds it.
module mxv_beat_writer
  import mxv_result_assembler_pkg::*;
#(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int count_width           = 3
) (
  input  logic [count_width-1:0]                         beat_count,
  input  logic [no_of_units*element_width-1:0]           in_data,
  output logic [no_of_eqn_per_cluster-1:0]               wr_en,
  output logic [no_of_eqn_per_cluster*element_width-1:0] wr_data
);

  // Row r lives in beat r/no_of_units at word r%no_of_units; both the beat word
  // order and the slot order put the lowest index in the most significant word.
  // Padding rows have no slot, so they are dropped simply by never being mapped.
  for (genvar r = 0; r < no_of_eqn_per_cluster; r++) begin : g_slot
    assign wr_en[r] = (beat_count == count_width'(r / no_of_units));
    assign wr_data[(no_of_eqn_per_cluster-1-r)*element_width +: element_width] =
      in_data[(no_of_units-1-(r % no_of_units))*element_width +: element_width];
  end

endmodule

// File: rtl/mxv_result_assembler.sv
// Assembles per-beat MxV partial results into one full result vector and hands
// it downstream with a valid/ack handshake, back-pressuring upstream meanwhile.
module mxv_result_assembler
  import mxv_result_assembler_pkg::*;
#(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int NI                    = 8,
  parameter int additional            = calc_additional(no_of_eqn_per_cluster, NI),
  parameter int total                 = no_of_eqn_per_cluster + additional,
  parameter int no_of_beats           = total / no_of_units,
  localparam int count_width          = $clog2(no_of_beats + 1)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           in_valid,
  input  logic [no_of_units*element_width-1:0]           in_data,
  output logic                                           in_ready,
  output logic [no_of_eqn_per_cluster*element_width-1:0] vec_out,
  output logic                                           vec_valid,
  input  logic                                           vec_ack,
  output logic [count_width-1:0]                         beat_count,
  output logic                                           busy
);

  state_t                                         state, state_next;
  logic [count_width-1:0]                         count, count_next;
  logic                                           accept;
  logic                                           last_beat;
  logic [no_of_eqn_per_cluster-1:0]               wr_en;
  logic [no_of_eqn_per_cluster*element_width-1:0] wr_data;
  logic [no_of_eqn_per_cluster*element_width-1:0] vec_q;

  // A beat dropped in the same cycle that start falls is abandoned with the rest.
  assign accept    = start && in_valid && (state == COLLECT);
  assign last_beat = (count == count_width'(no_of_beats - 1));

  assign in_ready   = (state == COLLECT);
  assign vec_valid  = (state == HOLD);
  assign busy       = (state == COLLECT) && (count != '0);
  assign beat_count = count;
  assign vec_out    = vec_q;

  mxv_beat_writer #(
    .no_of_eqn_per_cluster(no_of_eqn_per_cluster),
    .element_width        (element_width),
    .no_of_units          (no_of_units),
    .count_width          (count_width)
  ) u_beat_writer (
    .beat_count(count),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  // Next-state and beat counter; start low overrides everything to idle/clear.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: state_next = COLLECT;
      COLLECT: begin
        if (accept) begin
          count_next = count + count_width'(1);
          if (last_beat) state_next = HOLD;
        end
      end
      HOLD: begin
        if (vec_ack) begin
          state_next = COLLECT;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!start) begin
      state_next = IDLE;
      count_next = '0;
    end
  end

  // State and counter registers; reset takes priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Row-slot bank: only reset clears it, so an abort leaves old contents visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '0;
    end else begin
      for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
        if (accept && wr_en[r]) begin
          vec_q[(no_of_eqn_per_cluster-1-r)*element_width +: element_width] <=
            wr_data[(no_of_eqn_per_cluster-1-r)*element_width +: element_width];
        end
      end
    end
  end

endmodule

// File: tb/tb_mxv_result_assembler.sv
// Directed self-checking bench for mxv_result_assembler at defaults plus two
// smaller configurations (8 equations, and 4 equations with 2 beats).
module tb_mxv_result_assembler;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, sw_valid, vec_ack;
  logic [127:0] in_data;

  logic         in_ready, vec_valid, busy;
  logic [319:0] vec_out;
  logic [2:0]   beat_count;

  logic         in_ready8, vec_valid8, busy8;
  logic [255:0] vec_out8;
  logic [2:0]   beat_count8;

  logic         in_ready4, vec_valid4, busy4;
  logic [127:0] vec_out4;
  logic [1:0]   beat_count4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mxv_result_assembler dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .vec_out(vec_out), .vec_valid(vec_valid), .vec_ack(vec_ack),
    .beat_count(beat_count), .busy(busy)
  );

  mxv_result_assembler #(.no_of_eqn_per_cluster(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .in_valid(sw_valid), .in_data(in_data),
    .in_ready(in_ready8), .vec_out(vec_out8), .vec_valid(vec_valid8), .vec_ack(vec_ack),
    .beat_count(beat_count8), .busy(busy8)
  );

  mxv_result_assembler #(.no_of_eqn_per_cluster(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(sw_valid), .in_data(in_data),
    .in_ready(in_ready4), .vec_out(vec_out4), .vec_valid(vec_valid4), .vec_ack(vec_ack),
    .beat_count(beat_count4), .busy(busy4)
  );

  // One beat: word j (MS first) = base + 0x100*b + j.
  function automatic logic [127:0] beat(input int b, input logic [31:0] base);
    logic [31:0] w;
    w = base + 32'(b) * 32'h100;
    return {w, w + 32'd1, w + 32'd2, w + 32'd3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic v,
                               input logic [127:0] d, input logic ack);
    reset    = rst;
    start    = st;
    in_valid = v;
    in_data  = d;
    vec_ack  = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [319:0] observed,
                             input logic [319:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [319:0] exp1, exp2, exp3, exp_abort, exp4;

  initial begin
    exp1 = {32'h000, 32'h001, 32'h002, 32'h003, 32'h100, 32'h101, 32'h102, 32'h103,
            32'h200, 32'h201};
    exp2 = {32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1100, 32'h1101, 32'h1102,
            32'h1103, 32'h1200, 32'h1201};
    exp3 = {32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2100, 32'h2101, 32'h2102,
            32'h2103, 32'h2200, 32'h2201};
    exp_abort = {32'h3000, 32'h3001, 32'h3002, 32'h3003, 32'h3100, 32'h3101, 32'h3102,
                 32'h3103, 32'h2200, 32'h2201};
    exp4 = {32'h4000, 32'h4001, 32'h4002, 32'h4003, 32'h4100, 32'h4101, 32'h4102,
            32'h4103, 32'h4200, 32'h4201};

    sw_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    checkOutput("reset_vec_valid", 320'(vec_valid), 320'd0);
    checkOutput("reset_in_ready", 320'(in_ready), 320'd0);
    checkOutput("reset_beat_count", 320'(beat_count), 320'd0);
    checkOutput("reset_busy", 320'(busy), 320'd0);
    checkOutput("reset_vec_out", vec_out, 320'd0);

    // Scenario 1: full vector, in_valid held high
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    checkOutput("s1_in_ready", 320'(in_ready), 320'd1);
    checkOutput("s1_busy_before", 320'(busy), 320'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, beat(0, 32'h0), 1'b0);
    tick();
    checkOutput("s1_count1", 320'(beat_count), 320'd1);
    checkOutput("s1_busy1", 320'(busy), 320'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, beat(1, 32'h0), 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, beat(2, 32'h0), 1'b0);
    tick();
    checkOutput("s1_valid_early", 320'(vec_valid), 320'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, beat(3, 32'h0), 1'b0);
    tick();
    checkOutput("s1_vec_valid", 320'(vec_valid), 320'd1);
    checkOutput("s1_in_ready_hold", 320'(in_ready), 320'd0);
    checkOutput("s1_count4", 320'(beat_count), 320'd4);
    checkOutput("s1_busy_hold", 320'(busy), 320'd0);
    checkOutput("s1_vec_out", vec_out, exp1);

    // Scenario 2: beat offered during HOLD for 5 cycles without ack
    applyStimulus(1'b0, 1'b1, 1'b1, beat(0, 32'hdead0000), 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("s2_in_ready", 320'(in_ready), 320'd0);
    checkOutput("s2_vec_valid", 320'(vec_valid), 320'd1);
    checkOutput("s2_count", 320'(beat_count), 320'd4);
    checkOutput("s2_vec_frozen", vec_out, exp1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    tick();
    checkOutput("s2_ack_valid", 320'(vec_valid), 320'd0);
    checkOutput("s2_ack_ready", 320'(in_ready), 320'd1);
    checkOutput("s2_ack_count", 320'(beat_count), 320'd0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, beat(b, 32'h1000), 1'b0);
      tick();
    end
    checkOutput("s2_second_valid", 320'(vec_valid), 320'd1);
    checkOutput("s2_second_vec", vec_out, exp2);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    tick();

    // Ack while not valid is ignored
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    tick();
    checkOutput("stray_ack_ready", 320'(in_ready), 320'd1);
    checkOutput("stray_ack_valid", 320'(vec_valid), 320'd0);
    checkOutput("stray_ack_count", 320'(beat_count), 320'd0);

    // Scenario 3: gapped input 1,0,0 with garbage data on idle cycles
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, beat(b, 32'h2000), 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, beat(3, 32'hffff0000), 1'b0);
      tick();
      tick();
      if (b == 0) checkOutput("s3_count_gap", 320'(beat_count), 320'd1);
    end
    checkOutput("s3_valid", 320'(vec_valid), 320'd1);
    checkOutput("s3_vec", vec_out, exp3);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    tick();

    // Scenario 4: abort after 2 beats, then a full new vector
    for (int b = 0; b < 2; b++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, beat(b, 32'h3000), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    checkOutput("s4_count", 320'(beat_count), 320'd0);
    checkOutput("s4_busy", 320'(busy), 320'd0);
    checkOutput("s4_in_ready", 320'(in_ready), 320'd0);
    checkOutput("s4_vec_kept", vec_out, exp_abort);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, beat(b, 32'h4000), 1'b0);
      tick();
    end
    checkOutput("s4_valid", 320'(vec_valid), 320'd1);
    checkOutput("s4_vec", vec_out, exp4);

    // Scenario 5: reset during HOLD with start still high
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    tick();
    checkOutput("s5_valid", 320'(vec_valid), 320'd0);
    checkOutput("s5_ready", 320'(in_ready), 320'd0);
    checkOutput("s5_count", 320'(beat_count), 320'd0);
    checkOutput("s5_busy", 320'(busy), 320'd0);
    checkOutput("s5_vec", vec_out, 320'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick();

    // Scenario 6: parameter sweep on the 8- and 4-equation instances
    sw_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_data = beat(b, 32'h5000);
      tick();
    end
    checkOutput("s6_n4_valid", 320'(vec_valid4), 320'd1);
    checkOutput("s6_n4_vec", 320'(vec_out4), 320'({32'h5000, 32'h5001, 32'h5002, 32'h5003}));
    checkOutput("s6_n4_count", 320'(beat_count4), 320'd2);
    checkOutput("s6_n8_valid_early", 320'(vec_valid8), 320'd0);
    for (int b = 2; b < 4; b++) begin
      in_data = beat(b, 32'h5000);
      tick();
    end
    sw_valid = 1'b0;
    checkOutput("s6_n8_valid", 320'(vec_valid8), 320'd1);
    checkOutput("s6_n8_count", 320'(beat_count8), 320'd4);
    checkOutput("s6_n8_vec", 320'(vec_out8),
                320'({32'h5000, 32'h5001, 32'h5002, 32'h5003,
                      32'h5100, 32'h5101, 32'h5102, 32'h5103}));
    checkOutput("s6_n4_frozen", 320'(vec_out4), 320'({32'h5000, 32'h5001, 32'h5002, 32'h5003}));
    checkOutput("s6_n4_ready", 320'(in_ready4), 320'd0);
    checkOutput("s6_main_idle_count", 320'(beat_count), 320'd0);
    checkOutput("s6_main_vec", vec_out, 320'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
